// File: rtl/memory_stage.sv
// MEM stage of the RV32I pipeline: data-memory handshake, store lane steering, load alignment/extension.
// Optional build macro MISALIGN_TRAP_EN: misaligned half/word accesses retire without a memory request.
module memory_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              valid_in,
  input  logic [31:0]       alu_data_in,
  input  logic [31:0]       memory_data_in,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [2:0]        funct3,
  input  logic [4:0]        rd_in,
  input  logic              reg_write_in,
  output logic              stall,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  output logic [3:0]        dmem_be,
  input  logic              dmem_ack,
  input  logic [31:0]       dmem_rdata,
  output logic              wb_valid,
  output logic [31:0]       wb_data,
  output logic [4:0]        wb_rd,
  output logic              wb_reg_write,
  output logic [31:0]       mem_forward_data,
  output logic              bus_error
`ifdef MISALIGN_TRAP_EN
  ,
  output logic              misaligned
`endif
);

  typedef enum logic [0:0] {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t      state_r, state_nxt_s;
  logic [2:0]  funct3_r;
  logic [1:0]  off_r;
  logic [4:0]  rd_r;
  logic        reg_write_r;
  logic        is_load_r;
  logic [15:0] cnt_r;
  logic        mem_op_s;
  logic        trap_s;
  logic        timeout_s;

  // funct3[1:0]: 00 byte, 01 half, otherwise word
  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] be;
    case (f3[1:0])
      2'b00:   be = 4'b0001 << off;
      2'b01:   be = off[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] w;
    case (f3[1:0])
      2'b00:   w = {4{d[7:0]}};
      2'b01:   w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

  function automatic logic [31:0] load_align(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = off[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b100:  r = {24'h000000, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b101:  r = {16'h0000, h};
      default: r = w;
    endcase
    return r;
  endfunction

  assign mem_forward_data = wb_data;

  // next-state, combinational stall, misalignment detection
  always_comb begin
    mem_op_s    = mem_read | mem_write;
    trap_s      = 1'b0;
    timeout_s   = (cnt_r == 16'(TIMEOUT_CYCLES - 1));
    state_nxt_s = state_r;
    stall       = 1'b0;
`ifdef MISALIGN_TRAP_EN
    if (funct3[1]) begin
      trap_s = (alu_data_in[1:0] != 2'b00);
    end else if (funct3[0]) begin
      trap_s = alu_data_in[0];
    end else begin
      trap_s = 1'b0;
    end
`endif
    case (state_r)
      IDLE: begin
        if (valid_in && mem_op_s && !trap_s) begin
          state_nxt_s = WAIT;
          stall       = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WAIT: begin
        stall = 1'b1;
        if (dmem_ack || timeout_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = WAIT;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // state, memory request and writeback registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= IDLE;
      funct3_r     <= 3'd0;
      off_r        <= 2'd0;
      rd_r         <= 5'd0;
      reg_write_r  <= 1'b0;
      is_load_r    <= 1'b0;
      cnt_r        <= 16'd0;
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_addr    <= '0;
      dmem_wdata   <= 32'd0;
      dmem_be      <= 4'd0;
      wb_valid     <= 1'b0;
      wb_data      <= 32'd0;
      wb_rd        <= 5'd0;
      wb_reg_write <= 1'b0;
      bus_error    <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      misaligned   <= 1'b0;
`endif
    end else begin
      state_r      <= state_nxt_s;
      wb_valid     <= 1'b0;
      wb_reg_write <= 1'b0;
      bus_error    <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      misaligned   <= 1'b0;
`endif
      case (state_r)
        IDLE: begin
          if (valid_in && mem_op_s && !trap_s) begin
            dmem_req    <= 1'b1;
            dmem_we     <= ~mem_read;
            dmem_addr   <= {alu_data_in[ADDR_W-1:2], 2'b00};
            dmem_wdata  <= store_wdata(funct3, memory_data_in);
            dmem_be     <= store_be(funct3, alu_data_in[1:0]);
            funct3_r    <= funct3;
            off_r       <= alu_data_in[1:0];
            rd_r        <= rd_in;
            reg_write_r <= reg_write_in;
            is_load_r   <= mem_read;
            cnt_r       <= 16'd0;
`ifdef MISALIGN_TRAP_EN
          end else if (valid_in && mem_op_s) begin
            wb_valid    <= 1'b1;
            wb_rd       <= rd_in;
            misaligned  <= 1'b1;
`endif
          end else if (valid_in) begin
            wb_valid     <= 1'b1;
            wb_data      <= alu_data_in;
            wb_rd        <= rd_in;
            wb_reg_write <= reg_write_in;
          end else begin
            cnt_r <= 16'd0;
          end
        end
        WAIT: begin
          // ack takes priority over a timeout landing in the same cycle
          if (dmem_ack) begin
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            wb_valid     <= 1'b1;
            wb_rd        <= rd_r;
            wb_reg_write <= is_load_r & reg_write_r;
            if (is_load_r) begin
              wb_data <= load_align(funct3_r, off_r, dmem_rdata);
            end else begin
              wb_data <= wb_data;
            end
          end else if (timeout_s) begin
            dmem_req  <= 1'b0;
            dmem_we   <= 1'b0;
            bus_error <= 1'b1;
            wb_valid  <= 1'b1;
            wb_rd     <= rd_r;
          end else begin
            cnt_r <= cnt_r + 16'd1;
          end
        end
        default: dmem_req <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: table-driven load/store/pass-through vectors with a
// writeback scoreboard, plus hand-written timeout, reset-abort and idle-hold sequences.
module tb_memory_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        valid_in;
  logic [31:0] alu_data_in;
  logic [31:0] memory_data_in;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [4:0]  rd_in;
  logic        reg_write_in;
  logic        stall;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_reg_write;
  logic [31:0] mem_forward_data;
  logic        bus_error;
`ifdef MISALIGN_TRAP_EN
  logic        misaligned;
`endif

  int errors = 0;
  int checks = 0;

  memory_stage #(.TIMEOUT_CYCLES(4), .ADDR_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .valid_in(valid_in), .alu_data_in(alu_data_in),
    .memory_data_in(memory_data_in), .mem_read(mem_read), .mem_write(mem_write),
    .funct3(funct3), .rd_in(rd_in), .reg_write_in(reg_write_in), .stall(stall),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_be(dmem_be), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .wb_valid(wb_valid),
    .wb_data(wb_data), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .mem_forward_data(mem_forward_data), .bus_error(bus_error)
`ifdef MISALIGN_TRAP_EN
    , .misaligned(misaligned)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd_en;
    logic        wr_en;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [4:0]  rd;
    logic        rw;
    int          ack_wait;
    logic [31:0] rdata;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic [31:0] e_wb;
    logic        e_rw;
    logic        e_chk;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        rw;
    logic        chk;
    int          stall_n;
  } exp_t;

  vec_t vt[$];
  exp_t sb[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    mem_read       = v.rd_en;
    mem_write      = v.wr_en;
    funct3         = v.f3;
    alu_data_in    = v.addr;
    memory_data_in = v.sdata;
    rd_in          = v.rd;
    reg_write_in   = v.rw;
    valid_in       = 1'b1;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    exp_t e;
    exp_t got;
    int   waits;
    int   stalls;
    bit   done;
    bit   mem;
    bit   seen_req;
    mem       = v.rd_en | v.wr_en;
    e.data    = v.e_wb;
    e.rd      = v.rd;
    e.rw      = v.e_rw;
    e.chk     = v.e_chk;
    e.stall_n = mem ? 2 + v.ack_wait : 0;
    sb.push_back(e);
    @(negedge clk);
    drive(v);
    waits = 0; stalls = 0; done = 0; seen_req = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      #1;
      if (stall) stalls++;
      dmem_ack = 1'b0;
      if (dmem_req) begin
        if (!seen_req) begin
          seen_req = 1;
          chk($sformatf("v%0d dmem_we", idx), {31'd0, dmem_we}, {31'd0, v.wr_en & ~v.rd_en});
          chk($sformatf("v%0d dmem_addr", idx), dmem_addr, v.e_addr);
          if (v.wr_en && !v.rd_en) begin
            chk($sformatf("v%0d dmem_be", idx), {28'd0, dmem_be}, {28'd0, v.e_be});
            chk($sformatf("v%0d dmem_wdata", idx), dmem_wdata, v.e_wdata);
          end
        end
        if (waits == v.ack_wait) begin
          dmem_ack   = 1'b1;
          dmem_rdata = v.rdata;
        end
        waits++;
      end
      @(posedge clk);
      @(negedge clk);
      valid_in = 1'b0;
      dmem_ack = 1'b0;
      if (wb_valid) begin
        done = 1;
        if (sb.size() == 0) begin
          chk($sformatf("v%0d scoreboard empty", idx), 32'd1, 32'd0);
        end else begin
          got = sb.pop_front();
          if (got.chk) chk($sformatf("v%0d wb_data", idx), wb_data, got.data);
          if (got.chk) chk($sformatf("v%0d fwd_data", idx), mem_forward_data, got.data);
          chk($sformatf("v%0d wb_rd", idx), {27'd0, wb_rd}, {27'd0, got.rd});
          chk($sformatf("v%0d wb_reg_write", idx), {31'd0, wb_reg_write}, {31'd0, got.rw});
          chk($sformatf("v%0d stall_cycles", idx), stalls, got.stall_n);
          chk($sformatf("v%0d bus_error", idx), {31'd0, bus_error}, 32'd0);
        end
      end
    end
    chk($sformatf("v%0d req_seen", idx), {31'd0, seen_req}, {31'd0, mem});
    if (!done) chk($sformatf("v%0d wb_valid timeout", idx), 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int   n;
    //         rd wr  f3      addr          sdata         rd  rw ack rdata         e_addr        e_be     e_wdata       e_wb          e_rw  chk
    vt.push_back('{1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0, 5'd7,  1'b1, 2, 32'hDEAD_BEEF, 32'h0000_0100, 4'h0, 32'h0, 32'hDEAD_BEEF, 1'b1, 1'b1});
    vt.push_back('{1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0, 5'd3,  1'b1, 0, 32'h80FF_FF00, 32'h0000_0100, 4'h0, 32'h0, 32'hFFFF_FF80, 1'b1, 1'b1});
    vt.push_back('{1'b1, 1'b0, 3'b100, 32'h0000_0103, 32'h0, 5'd4,  1'b1, 1, 32'h80FF_FF00, 32'h0000_0100, 4'h0, 32'h0, 32'h0000_0080, 1'b1, 1'b1});
    vt.push_back('{1'b1, 1'b0, 3'b101, 32'h0000_0102, 32'h0, 5'd6,  1'b1, 0, 32'h80FF_FF00, 32'h0000_0100, 4'h0, 32'h0, 32'h0000_80FF, 1'b1, 1'b1});
    vt.push_back('{1'b0, 1'b1, 3'b000, 32'h0000_0201, 32'h1234_5678, 5'd9, 1'b1, 0, 32'h0, 32'h0000_0200, 4'b0010, 32'h7878_7878, 32'h0, 1'b0, 1'b0});
    vt.push_back('{1'b0, 1'b0, 3'b000, 32'h0000_0042, 32'h0, 5'd5,  1'b1, 0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0000_0042, 1'b1, 1'b1});
    vt.push_back('{1'b1, 1'b0, 3'b001, 32'h0000_0100, 32'h0, 5'd10, 1'b1, 0, 32'h1234_8001, 32'h0000_0100, 4'h0, 32'h0, 32'hFFFF_8001, 1'b1, 1'b1});
    vt.push_back('{1'b0, 1'b1, 3'b001, 32'h0000_0102, 32'h0000_ABCD, 5'd11, 1'b0, 1, 32'h0, 32'h0000_0100, 4'b1100, 32'hABCD_ABCD, 32'h0, 1'b0, 1'b0});
    vt.push_back('{1'b0, 1'b1, 3'b010, 32'h0000_0300, 32'hCAFE_F00D, 5'd12, 1'b1, 1, 32'h0, 32'h0000_0300, 4'b1111, 32'hCAFE_F00D, 32'h0, 1'b0, 1'b0});
`ifndef MISALIGN_TRAP_EN
    vt.push_back('{1'b1, 1'b0, 3'b010, 32'h0000_0102, 32'h0, 5'd13, 1'b1, 0, 32'h1122_3344, 32'h0000_0100, 4'h0, 32'h0, 32'h1122_3344, 1'b1, 1'b1});
`endif
    vt.push_back('{1'b1, 1'b1, 3'b100, 32'h0000_0101, 32'hFFFF_FFFF, 5'd14, 1'b1, 0, 32'h0000_AB00, 32'h0000_0100, 4'h0, 32'h0, 32'h0000_00AB, 1'b1, 1'b1});
    vt.push_back('{1'b1, 1'b0, 3'b011, 32'h0000_0104, 32'h0, 5'd15, 1'b1, 0, 32'h55AA_55AA, 32'h0000_0104, 4'h0, 32'h0, 32'h55AA_55AA, 1'b1, 1'b1});
    vt.push_back('{1'b1, 1'b0, 3'b010, 32'h0000_0108, 32'h0, 5'd16, 1'b1, 3, 32'h0BAD_F00D, 32'h0000_0108, 4'h0, 32'h0, 32'h0BAD_F00D, 1'b1, 1'b1});
    vt.push_back('{1'b0, 1'b0, 3'b010, 32'h0000_ABCD, 32'h0, 5'd17, 1'b0, 0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0000_ABCD, 1'b0, 1'b1});

    reset_n = 1'b0; valid_in = 1'b0; alu_data_in = 32'd0; memory_data_in = 32'd0;
    mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'd0; rd_in = 5'd0; reg_write_in = 1'b0;
    dmem_ack = 1'b0; dmem_rdata = 32'd0;
    repeat (2) @(negedge clk);
    chk("reset dmem_req", {31'd0, dmem_req}, 32'd0);
    chk("reset wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("reset wb_data", wb_data, 32'd0);
    chk("reset stall", {31'd0, stall}, 32'd0);
    chk("reset bus_error", {31'd0, bus_error}, 32'd0);
    reset_n = 1'b1;

    for (int i = 0; i < vt.size(); i++) run_vec(i, vt[i]);

    // idle after a pass-through: pulse ends, data holds
    v = vt[5];
    v.addr = 32'h0000_0099;
    @(negedge clk);
    drive(v);
    @(posedge clk);
    @(negedge clk);
    valid_in = 1'b0;
    chk("pass wb_data", wb_data, 32'h0000_0099);
    @(posedge clk);
    @(negedge clk);
    chk("idle wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("idle wb_reg_write", {31'd0, wb_reg_write}, 32'd0);
    chk("idle wb_data hold", wb_data, 32'h0000_0099);

    // timeout: no ack, request held for TIMEOUT_CYCLES cycles
    v = vt[0];
    v.rd = 5'd21;
    @(negedge clk);
    drive(v);
    n = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      @(negedge clk);
      valid_in = 1'b0;
      if (bus_error) break;
      if (dmem_req) n++;
    end
    chk("timeout req_cycles", n, 4);
    chk("timeout bus_error", {31'd0, bus_error}, 32'd1);
    chk("timeout wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("timeout wb_reg_write", {31'd0, wb_reg_write}, 32'd0);
    chk("timeout wb_rd", {27'd0, wb_rd}, 32'd21);
    chk("timeout dmem_req", {31'd0, dmem_req}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("timeout pulse end", {31'd0, bus_error}, 32'd0);

    // asynchronous reset in the middle of a wait
    @(negedge clk);
    drive(vt[0]);
    @(posedge clk);
    @(negedge clk);
    valid_in = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midwait dmem_req", {31'd0, dmem_req}, 32'd1);
    #1 reset_n = 1'b0;
    #1;
    chk("abort dmem_req", {31'd0, dmem_req}, 32'd0);
    chk("abort stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("abort no retry", {31'd0, dmem_req}, 32'd0);
    chk("abort idle stall", {31'd0, stall}, 32'd0);

`ifdef MISALIGN_TRAP_EN
    v = vt[0];
    v.addr = 32'h0000_0102;
    @(negedge clk);
    drive(v);
    #1;
    chk("trap stall", {31'd0, stall}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    valid_in = 1'b0;
    chk("trap misaligned", {31'd0, misaligned}, 32'd1);
    chk("trap wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("trap wb_reg_write", {31'd0, wb_reg_write}, 32'd0);
    chk("trap dmem_req", {31'd0, dmem_req}, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
